// File: rtl/spram_pkg.sv
// Shared constants for the 32-bit-to-16-bit SPRAM sequencer.
package spram_pkg;

  localparam int SPRAM_HADR_W = 14;  // halfword address width of one SPRAM
  localparam int SPRAM_DW     = 16;  // SPRAM data width

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAKE = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Two byte enables of one half -> four nibble write enables.
  function automatic logic [3:0] sel2mask(input logic [1:0] sel);
    return {sel[1], sel[1], sel[0], sel[0]};
  endfunction

endpackage

// File: rtl/spram_lanemap.sv
// Selects the active 16-bit half of the bus word and its nibble mask.
module spram_lanemap
  import spram_pkg::*;
(
  input  logic [3:0]          i_sel,
  input  logic [31:0]         i_dat,
  input  logic                i_half,
  output logic [3:0]          o_mask,
  output logic [SPRAM_DW-1:0] o_din
);

  assign o_mask = i_half ? sel2mask(i_sel[3:2]) : sel2mask(i_sel[1:0]);
  assign o_din  = i_half ? i_dat[31:16] : i_dat[15:0];

endmodule

// File: rtl/spram32_seq.sv
// Wishbone-classic 32-bit word port onto one 16-bit iCE40UP SPRAM.
// Each access is split into a low-half then high-half SPRAM cycle; read
// data of the low half is parked in r_lo until the high half returns.
// STANDBY is requested after IDLE_SBY idle cycles and released via WAKE.
module spram32_seq
  import spram_pkg::*;
#(
  parameter int AW       = 13,
  parameter int IDLE_SBY = 0,
  parameter int CNTW     = 8
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    CYC_I,
  input  logic                    STB_I,
  input  logic                    WE_I,
  input  logic [AW-1:0]           ADR_I,
  input  logic [3:0]              SEL_I,
  input  logic [31:0]             DAT_I,
  output logic [31:0]             DAT_O,
  output logic                    ACK_O,
  output logic [SPRAM_HADR_W-1:0] SP_ADDRESS,
  output logic [SPRAM_DW-1:0]     SP_DATAIN,
  output logic [3:0]              SP_MASKWREN,
  output logic                    SP_WREN,
  output logic                    SP_CS,
  output logic                    SP_STANDBY,
  output logic                    SP_SLEEP,
  output logic                    SP_POWEROFF,
  input  logic [SPRAM_DW-1:0]     SP_DATAOUT
);

  logic [1:0]          r_state;
  logic [CNTW-1:0]     r_cnt;
  logic                r_sby;
  logic [SPRAM_DW-1:0] r_lo;

  logic [1:0]      w_state_nxt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic            w_sby_nxt;
  logic            w_req;
  logic            w_cs;
  logic            w_half;
  logic            w_wren;
  logic            w_ack;
  logic            w_sby_o;
  logic [12:0]     w_wadr;

  assign w_req = CYC_I & STB_I;

  // Only 13 word-address bits reach one SPRAM; wider buses alias.
  generate
    if (AW >= 13) begin : g_adr
      assign w_wadr = ADR_I[12:0];
    end else begin : g_pad
      assign w_wadr = {{(13-AW){1'b0}}, ADR_I};
    end
  endgenerate

  // Next state, idle counter and standby request.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_sby_nxt   = r_sby;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = r_sby ? S_WAKE : S_HI;
          w_sby_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
          if (IDLE_SBY != 0 && w_cnt_nxt == CNTW'(IDLE_SBY))
            w_sby_nxt = 1'b1;
        end
      end
      S_WAKE:  w_state_nxt = S_HI;
      S_HI:    w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counter, standby and low-half read capture; reset dominates.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sby   <= 1'b0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sby   <= w_sby_nxt;
      if (r_state == S_HI)
        r_lo <= SP_DATAOUT;
    end
  end

  // SPRAM strobes from state plus held bus inputs. Reset suppresses every
  // strobe combinationally so an interrupted write never hits the high half.
  always_comb begin
    w_cs    = 1'b0;
    w_half  = 1'b0;
    w_wren  = 1'b0;
    w_ack   = 1'b0;
    w_sby_o = r_sby;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (r_sby) begin
            w_sby_o = 1'b0;
          end else begin
            w_cs   = 1'b1;
            w_wren = WE_I & (|SEL_I[1:0]);
          end
        end
      end
      S_WAKE: begin
        w_cs   = 1'b1;
        w_wren = WE_I & (|SEL_I[1:0]);
      end
      S_HI: begin
        w_cs   = 1'b1;
        w_half = 1'b1;
        w_wren = WE_I & (|SEL_I[3:2]);
      end
      default: w_ack = 1'b1;
    endcase
    if (RST_I) begin
      w_cs    = 1'b0;
      w_wren  = 1'b0;
      w_ack   = 1'b0;
      w_sby_o = 1'b0;
    end
  end

  spram_lanemap u_lanemap (
    .i_sel  (SEL_I),
    .i_dat  (DAT_I),
    .i_half (w_half),
    .o_mask (SP_MASKWREN),
    .o_din  (SP_DATAIN)
  );

  assign SP_ADDRESS  = {w_wadr, w_half};
  assign SP_CS       = w_cs;
  assign SP_WREN     = w_wren;
  assign SP_STANDBY  = w_sby_o;
  assign SP_SLEEP    = 1'b0;
  assign SP_POWEROFF = 1'b1;
  assign ACK_O       = w_ack;
  assign DAT_O       = w_ack ? {SP_DATAOUT, r_lo} : 32'h0;

endmodule

// File: tb/tb_spram32_seq.sv
// Self-checking bench for spram32_seq driving a behavioural 16-bit SPRAM.
module tb_spram32_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cyc, stb, we;
  logic [12:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_i, dat_o;
  logic        ack;
  logic [13:0] sp_addr;
  logic [15:0] sp_din, sp_dout;
  logic [3:0]  sp_mask;
  logic        sp_wren, sp_cs, sp_sby, sp_sleep, sp_pwr;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] data;
    int          lat;
    logic        chk;
  } exp_t;
  exp_t sb[$];

  spram32_seq #(.AW(13), .IDLE_SBY(4), .CNTW(8)) dut (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we),
    .ADR_I(adr), .SEL_I(sel), .DAT_I(dat_i), .DAT_O(dat_o), .ACK_O(ack),
    .SP_ADDRESS(sp_addr), .SP_DATAIN(sp_din), .SP_MASKWREN(sp_mask),
    .SP_WREN(sp_wren), .SP_CS(sp_cs), .SP_STANDBY(sp_sby),
    .SP_SLEEP(sp_sleep), .SP_POWEROFF(sp_pwr), .SP_DATAOUT(sp_dout)
  );

  // Behavioural SPRAM: nibble-masked write, registered read.
  logic [15:0] mem [0:16383];
  always @(posedge clk) begin
    if (sp_cs && !sp_sby && sp_pwr && !sp_sleep) begin
      if (sp_wren) begin
        for (int k = 0; k < 4; k++)
          if (sp_mask[k]) mem[sp_addr][4*k +: 4] <= sp_din[4*k +: 4];
      end else begin
        sp_dout <= mem[sp_addr];
      end
    end
  end

  // Observe what the RAM sees at each clock edge.
  int          mon_wren = 0, mon_wren_hi = 0, mon_top = 0, mon_cs_sby = 0;
  logic [3:0]  mon_lo_mask = 4'h0;
  always @(posedge clk) begin
    if (sp_cs && sp_wren) mon_wren <= mon_wren + 1;
    if (sp_cs && sp_wren && sp_addr[0]) mon_wren_hi <= mon_wren_hi + 1;
    if (sp_cs && sp_addr == 14'h3FFF) mon_top <= mon_top + 1;
    if (sp_cs && sp_sby) mon_cs_sby <= mon_cs_sby + 1;
    if (sp_cs && !sp_addr[0]) mon_lo_mask <= sp_mask;
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Drive one request (called at a negedge) and wait a bounded time for ACK.
  task automatic xfer(input logic w, input logic [12:0] a, input logic [3:0] s,
                      input logic [31:0] d, output int lat, output logic [31:0] rd,
                      output logic got);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
    lat = 0; got = 1'b0; rd = '0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(posedge clk); @(negedge clk);
      if (ack === 1'b1) begin got = 1'b1; lat = i; rd = dat_o; end
    end
  endtask

  task automatic idle_bus(input int n);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic test_reset;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat_i = '0;
    repeat (2) @(negedge clk);
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0", ack); end
    n_vec++; if (sp_cs !== 1'b0) begin n_err++; $display("FAIL rst_cs: got %b want 0", sp_cs); end
    n_vec++; if (sp_wren !== 1'b0) begin n_err++; $display("FAIL rst_wren: got %b want 0", sp_wren); end
    n_vec++; if (sp_sby !== 1'b0) begin n_err++; $display("FAIL rst_sby: got %b want 0", sp_sby); end
    n_vec++; if (dat_o !== 32'h0) begin n_err++; $display("FAIL rst_dat: got %h want 0", dat_o); end
    n_vec++; if (sp_sleep !== 1'b0 || sp_pwr !== 1'b1) begin
      n_err++; $display("FAIL rst_pwr: got sleep=%b poweroff=%b want 0/1", sp_sleep, sp_pwr);
    end
    rst = 1'b0;
    idle_bus(1);
  endtask

  task automatic test_full_word;
    int lat; logic [31:0] rd; logic got; exp_t e;
    sb.push_back('{32'h0, 2, 1'b0});
    xfer(1'b1, 13'd5, 4'hF, 32'hDEADBEEF, lat, rd, got);
    e = sb.pop_front();
    n_vec++; if (!got || lat != e.lat) begin n_err++; $display("FAIL wr5_lat: got %0d want %0d", lat, e.lat); end
    idle_bus(1);
    n_vec++; if (mem[10] !== 16'hBEEF) begin n_err++; $display("FAIL wr5_hw10: got %h want beef", mem[10]); end
    n_vec++; if (mem[11] !== 16'hDEAD) begin n_err++; $display("FAIL wr5_hw11: got %h want dead", mem[11]); end
    sb.push_back('{32'hDEADBEEF, 2, 1'b1});
    xfer(1'b0, 13'd5, 4'hF, 32'h0, lat, rd, got);
    e = sb.pop_front();
    n_vec++; if (!got || lat != e.lat) begin n_err++; $display("FAIL rd5_lat: got %0d want %0d", lat, e.lat); end
    n_vec++; if (rd !== e.data) begin n_err++; $display("FAIL rd5_data: got %h want %h", rd, e.data); end
    idle_bus(1);
  endtask

  task automatic test_byte_write;
    int lat, hi0; logic [31:0] rd; logic got; exp_t e;
    hi0 = mon_wren_hi;
    sb.push_back('{32'h0, 2, 1'b0});
    xfer(1'b1, 13'd5, 4'b0010, 32'h0000AA00, lat, rd, got);
    e = sb.pop_front();
    n_vec++; if (!got || lat != e.lat) begin n_err++; $display("FAIL bw_lat: got %0d want %0d", lat, e.lat); end
    n_vec++; if (mon_lo_mask !== 4'b1100) begin n_err++; $display("FAIL bw_mask: got %b want 1100", mon_lo_mask); end
    n_vec++; if (mon_wren_hi != hi0) begin n_err++; $display("FAIL bw_hi_wren: got %0d want 0 high writes", mon_wren_hi - hi0); end
    idle_bus(1);
    sb.push_back('{merge(32'hDEADBEEF, 32'h0000AA00, 4'b0010), 2, 1'b1});
    xfer(1'b0, 13'd5, 4'hF, 32'h0, lat, rd, got);
    e = sb.pop_front();
    n_vec++; if (!got || rd !== e.data) begin n_err++; $display("FAIL bw_read: got %h want %h", rd, e.data); end
    idle_bus(1);
  endtask

  task automatic test_standby;
    int lat, cs0; logic [31:0] rd; logic got; exp_t e;
    cs0 = mon_cs_sby;
    idle_bus(3);
    n_vec++; if (sp_sby !== 1'b0) begin n_err++; $display("FAIL sby_early: got %b want 0", sp_sby); end
    idle_bus(1);
    n_vec++; if (sp_sby !== 1'b1) begin n_err++; $display("FAIL sby_set: got %b want 1", sp_sby); end
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 13'd5; sel = 4'hF;
    #1;
    n_vec++; if (sp_sby !== 1'b0 || sp_cs !== 1'b0) begin
      n_err++; $display("FAIL sby_wake: got sby=%b cs=%b want 0/0", sp_sby, sp_cs);
    end
    sb.push_back('{32'hDEADAAEF, 3, 1'b1});
    xfer(1'b0, 13'd5, 4'hF, 32'h0, lat, rd, got);
    e = sb.pop_front();
    n_vec++; if (!got || lat != e.lat) begin n_err++; $display("FAIL sby_lat: got %0d want %0d", lat, e.lat); end
    n_vec++; if (rd !== e.data) begin n_err++; $display("FAIL sby_data: got %h want %h", rd, e.data); end
    n_vec++; if (sp_sby !== 1'b0 || mon_cs_sby != cs0) begin
      n_err++; $display("FAIL sby_access: got sby=%b cs_in_sby=%0d want 0/0", sp_sby, mon_cs_sby - cs0);
    end
    idle_bus(1);
  endtask

  task automatic test_reset_in_hi;
    int lat; logic [31:0] rd; logic got; exp_t e;
    sb.push_back('{32'h0, 2, 1'b0});
    xfer(1'b1, 13'd7, 4'hF, 32'hCAFEF00D, lat, rd, got);
    e = sb.pop_front();
    n_vec++; if (!got || lat != e.lat) begin n_err++; $display("FAIL pre7_lat: got %0d want %0d", lat, e.lat); end
    idle_bus(1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 13'd7; sel = 4'hF; dat_i = 32'h12345678;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++; if (ack !== 1'b0 || sp_wren !== 1'b0) begin
      n_err++; $display("FAIL rhi_strobe: got ack=%b wren=%b want 0/0", ack, sp_wren);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL rhi_ack: got %b want 0", ack); end
    n_vec++; if (mem[14] !== 16'h5678) begin n_err++; $display("FAIL rhi_hw14: got %h want 5678", mem[14]); end
    n_vec++; if (mem[15] !== 16'hCAFE) begin n_err++; $display("FAIL rhi_hw15: got %h want cafe", mem[15]); end
    sb.push_back('{32'hCAFE5678, 2, 1'b1});
    xfer(1'b0, 13'd7, 4'hF, 32'h0, lat, rd, got);
    e = sb.pop_front();
    n_vec++; if (!got || lat != e.lat || rd !== e.data) begin
      n_err++; $display("FAIL rhi_read: got lat=%0d data=%h want lat=%0d data=%h", lat, rd, e.lat, e.data);
    end
    idle_bus(1);
  endtask

  task automatic test_back_to_back;
    int lat, top0; logic [31:0] rd; logic got; exp_t e;
    xfer(1'b1, 13'd0, 4'hF, 32'h0BADF00D, lat, rd, got);
    idle_bus(1);
    xfer(1'b1, 13'd8191, 4'hF, 32'h76543210, lat, rd, got);
    idle_bus(1);
    top0 = mon_top;
    sb.push_back('{32'h0BADF00D, 2, 1'b1});
    sb.push_back('{32'h76543210, 3, 1'b1});
    xfer(1'b0, 13'd0, 4'hF, 32'h0, lat, rd, got);
    e = sb.pop_front();
    n_vec++; if (!got || lat != e.lat || rd !== e.data) begin
      n_err++; $display("FAIL b2b_w0: got lat=%0d data=%h want lat=%0d data=%h", lat, rd, e.lat, e.data);
    end
    xfer(1'b0, 13'd8191, 4'hF, 32'h0, lat, rd, got);
    e = sb.pop_front();
    n_vec++; if (!got || lat != e.lat || rd !== e.data) begin
      n_err++; $display("FAIL b2b_w8191: got lat=%0d data=%h want lat=%0d data=%h", lat, rd, e.lat, e.data);
    end
    idle_bus(1);
    n_vec++; if (mon_top == top0) begin n_err++; $display("FAIL b2b_top: got 0 accesses at 3fff want >0"); end
  endtask

  task automatic test_sel_zero;
    int lat, w0; logic [31:0] rd; logic got; exp_t e;
    w0 = mon_wren;
    sb.push_back('{32'h0, 2, 1'b0});
    xfer(1'b1, 13'd5, 4'b0000, 32'hFFFFFFFF, lat, rd, got);
    e = sb.pop_front();
    n_vec++; if (!got || lat != e.lat) begin n_err++; $display("FAIL sel0_lat: got %0d want %0d", lat, e.lat); end
    idle_bus(1);
    n_vec++; if (mon_wren != w0) begin n_err++; $display("FAIL sel0_wren: got %0d writes want 0", mon_wren - w0); end
    n_vec++; if (mem[10] !== 16'hAAEF || mem[11] !== 16'hDEAD) begin
      n_err++; $display("FAIL sel0_mem: got %h%h want deadaaef", mem[11], mem[10]);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_byte_write();
    test_standby();
    test_reset_in_hi();
    test_back_to_back();
    test_sel_zero();
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_empty: got %0d left want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
